// File: rtl/sw_debounce.sv
// Four-channel slide-switch conditioner: 2-flop synchroniser, tick-paced debounce,
// registered rise/fall/change strobes and an any-switch-on flag.
module sw_debounce #(
   parameter int unsigned DIV          = 10,
   parameter int unsigned STABLE_TICKS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] sw,
   output logic [3:0] sw_db,
   output logic [3:0] rise,
   output logic [3:0] fall,
   output logic       change,
   output logic       any_on,
   output logic       tick
);

   localparam logic [15:0] DIV_TC = 16'(DIV);
   localparam logic [7:0]  CNT_TC = 8'(STABLE_TICKS - 1);

   logic [15:0] div_cnt_q, div_cnt_d;
   logic [3:0]  s1_q, s2_q;
   logic [7:0]  cnt_q [4];
   logic [7:0]  cnt_d [4];
   logic [3:0]  sw_db_q, sw_db_d;
   logic [3:0]  rise_q, rise_d;
   logic [3:0]  fall_q, fall_d;
   logic        change_q, change_d;

   // Free-running divider; never restarted by switch activity.
   always_comb begin
      tick      = (div_cnt_q == DIV_TC);
      div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
   end

   always_comb begin
      cnt_d   = cnt_q;
      sw_db_d = sw_db_q;
      rise_d  = 4'b0000;
      fall_d  = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         if (s2_q[k] == sw_db_q[k]) begin
            cnt_d[k] = 8'd0;
         end else if (tick) begin
            if (cnt_q[k] == CNT_TC) begin
               sw_db_d[k] = s2_q[k];
               cnt_d[k]   = 8'd0;
               rise_d[k]  = s2_q[k];
               fall_d[k]  = ~s2_q[k];
            end else begin
               cnt_d[k] = cnt_q[k] + 8'd1;
            end
         end
      end
      change_d = |(rise_d | fall_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= 16'd0;
         s1_q      <= 4'b0000;
         s2_q      <= 4'b0000;
         cnt_q     <= '{default: 8'd0};
         sw_db_q   <= 4'b0000;
         rise_q    <= 4'b0000;
         fall_q    <= 4'b0000;
         change_q  <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         s1_q      <= sw;
         s2_q      <= s1_q;
         cnt_q     <= cnt_d;
         sw_db_q   <= sw_db_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         change_q  <= change_d;
      end
   end

   assign sw_db  = sw_db_q;
   assign rise   = rise_q;
   assign fall   = fall_q;
   assign change = change_q;
   assign any_on = |sw_db_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: vector table plus scoreboard of expected strobes,
// with hand sequences for reset, bounce and mid-debounce reset.
module tb_sw_debounce;
   localparam int DIV     = 3;
   localparam int ST      = 2;
   localparam int LAT_MIN = 3 + (ST - 1) * (DIV + 1);
   localparam int LAT_MAX = 2 + ST * (DIV + 1);

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] sw    = 4'hF;
   logic [3:0] sw_db, rise, fall;
   logic       change, any_on, tick;

   typedef struct {
      logic [3:0] sw;
      logic [3:0] db;
      logic [3:0] rise;
      logic [3:0] fall;
   } vec_t;

   typedef struct {
      logic [3:0] db;
      logic [3:0] rise;
      logic [3:0] fall;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   vec_t tbl[9];
   int   n_vec      = 0;
   int   n_err      = 0;
   int   strobe_cnt = 0;

   sw_debounce #(.DIV(DIV), .STABLE_TICKS(ST)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw     (sw),
      .sw_db  (sw_db),
      .rise   (rise),
      .fall   (fall),
      .change (change),
      .any_on (any_on),
      .tick   (tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [3:0] db, input logic [3:0] r, input logic [3:0] f);
      exp_t e;
      e.db = db; e.rise = r; e.fall = f;
      sb_q.push_back(e);
   endtask

   // Edge 1 is the first edge sampling the new switch value (or the first edge after release).
   task automatic wait_commit(input string name, input bit expect_chg, input logic [3:0] exp_db);
      int n = 0;
      bit seen = 1'b0;
      for (int k = 1; k <= LAT_MAX + 4; k++) begin
         @(posedge clk); #1;
         if (!seen && change === 1'b1) begin
            seen = 1'b1;
            n    = k;
         end
      end
      if (expect_chg) begin
         chk({name, "_seen"}, 32'(seen), 32'd1);
         n_vec++;
         if (n < LAT_MIN || n > LAT_MAX) begin
            n_err++;
            $display("FAIL %s_latency: got %0d edges, required %0d..%0d", name, n, LAT_MIN, LAT_MAX);
         end
      end else begin
         chk({name, "_nochange"}, 32'(seen), 32'd0);
      end
      chk({name, "_sw_db"}, 32'(sw_db), 32'(exp_db));
      chk({name, "_any_on"}, 32'(any_on), 32'(|exp_db));
      chk({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && (change !== 1'b0 || rise !== 4'h0 || fall !== 4'h0)) begin
         strobe_cnt++;
         if (sb_q.size() == 0) begin
            chk("unexpected_strobe", 32'({change, rise, fall}), 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("strobe_rise", 32'(rise), 32'(mon_e.rise));
            chk("strobe_fall", 32'(fall), 32'(mon_e.fall));
            chk("strobe_change", 32'(change), 32'd1);
            chk("strobe_sw_db", 32'(sw_db), 32'(mon_e.db));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit bad;
      int p;
      int s0;

      tbl[0] = '{sw: 4'b0001, db: 4'b0001, rise: 4'b0001, fall: 4'b0000};
      tbl[1] = '{sw: 4'b0011, db: 4'b0011, rise: 4'b0010, fall: 4'b0000};
      tbl[2] = '{sw: 4'b1100, db: 4'b1100, rise: 4'b1100, fall: 4'b0011};
      tbl[3] = '{sw: 4'b1000, db: 4'b1000, rise: 4'b0000, fall: 4'b0100};
      tbl[4] = '{sw: 4'b0000, db: 4'b0000, rise: 4'b0000, fall: 4'b1000};
      tbl[5] = '{sw: 4'b0000, db: 4'b0000, rise: 4'b0000, fall: 4'b0000};
      tbl[6] = '{sw: 4'b1111, db: 4'b1111, rise: 4'b1111, fall: 4'b0000};
      tbl[7] = '{sw: 4'b0110, db: 4'b0110, rise: 4'b0000, fall: 4'b1001};
      tbl[8] = '{sw: 4'b0011, db: 4'b0011, rise: 4'b0001, fall: 4'b0100};

      // Reset held with all switches on.
      #1 rst_n = 1'b0;
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if ({tick, any_on, change, rise, fall, sw_db} !== 15'd0) bad = 1'b1;
      end
      chk("reset_quiet", 32'(bad), 32'd0);
      chk("reset_sw_db", 32'(sw_db), 32'd0);

      // Switches already on at release debounce normally.
      @(posedge clk); #1 rst_n = 1'b1;
      push_exp(4'hF, 4'hF, 4'h0);
      wait_commit("release_on", 1'b1, 4'hF);

      // Divider period.
      p = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (tick) break;
      end
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (tick === 1'b1) begin p = k; break; end
      end
      chk("tick_period", 32'(p), 32'(DIV + 1));

      @(posedge clk); #1 sw = 4'h0;
      push_exp(4'h0, 4'h0, 4'hF);
      wait_commit("all_off", 1'b1, 4'h0);

      // Bounce on bit 1: 3-cycle toggles never span two ticks.
      s0 = strobe_cnt;
      @(posedge clk); #1;
      for (int i = 0; i < 14; i++) begin
         sw = sw ^ 4'b0010;
         repeat (3) @(posedge clk);
         #1;
      end
      sw = 4'h0;
      wait_commit("bounce", 1'b0, 4'h0);
      chk("bounce_strobes", 32'(strobe_cnt - s0), 32'd0);

      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1 sw = tbl[i].sw;
         if ((tbl[i].rise | tbl[i].fall) != 4'h0) push_exp(tbl[i].db, tbl[i].rise, tbl[i].fall);
         wait_commit($sformatf("vec%0d", i), (tbl[i].rise | tbl[i].fall) != 4'h0, tbl[i].db);
      end

      // Reset mid-debounce on bit 2 (one tick of progress), then full latency from release.
      @(posedge clk); #1 sw = 4'b0111;
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_sw_db", 32'(sw_db), 32'd0);
      chk("midrst_any_on", 32'(any_on), 32'd0);
      chk("midrst_strobes", 32'({change, rise, fall}), 32'd0);
      chk("midrst_tick", 32'(tick), 32'd0);
      @(posedge clk); #1;
      chk("midrst_hold_sw_db", 32'(sw_db), 32'd0);
      rst_n = 1'b1;
      push_exp(4'b0111, 4'b0111, 4'b0000);
      wait_commit("post_reset", 1'b1, 4'b0111);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input-side conditioner for the four board slide switches feeding the LED pattern logic. It synchronises the raw `sw[3:0]` pins into the `clk` domain and debounces each channel against a slow divided tick. It delivers clean levels, one-cycle rise/fall/change strobes, and an any-switch-on flag, so downstream pattern and mode logic never sees bounce or metastability.

## Interface
- `DIV`, default 10: tick divider terminal count; tick period = DIV+1 clk cycles; legal 1..2^16-1
- `STABLE_TICKS`, default 4: consecutive ticks a channel must stay changed before commit; legal 1..255
- `clk` input 1: single system clock; all logic on rising edge
- `rst_n` input 1: asynchronous, active-low reset; one clock, no other clock or reset in the block
- `sw` input 4: raw switch pins, asynchronous to `clk`
- `sw_db` output 4: debounced switch levels
- `rise` output 4: one-cycle pulse per channel on debounced 0->1
- `fall` output 4: one-cycle pulse per channel on debounced 1->0
- `change` output 1: one-cycle pulse when any bit of `sw_db` changes (= |(rise|fall))
- `any_on` output 1: |sw_db (combinational from `sw_db`)
- `tick` output 1: divider strobe, exported for the downstream LED stepper

## Operation
- Tick divider: `div_cnt` counts 0..DIV. When `div_cnt==DIV`, `tick` is high for that cycle and `div_cnt` wraps to 0 on the next edge; otherwise it increments. `tick` is combinational from `div_cnt`.
- Synchroniser: two flops per bit, `sw` -> `s1` -> `s2`. Only `s2` is used by the debounce logic.
- Per-channel debounce, with independent 8-bit `cnt[k]`, evaluated each edge:
  - `s2[k]==sw_db[k]`: `cnt[k]`<=0; no strobe. A glitch that returns before commit fully discards progress.
  - mismatch, no tick: `cnt[k]` holds.
  - mismatch, tick, `cnt[k]<STABLE_TICKS-1`: `cnt[k]`++.
  - mismatch, tick, `cnt[k]==STABLE_TICKS-1`: commit. `sw_db[k]`<=`s2[k]` and `cnt[k]`<=0. `rise[k]` or `fall[k]` is set to 1 on the same edge.
- Strobes are registered. `rise`, `fall` and `change` are high for exactly one cycle, the first cycle `sw_db` shows the new value. Otherwise they are 0.
- Channels are fully independent. Simultaneous commits on several channels in one cycle assert several `rise`/`fall` bits with a single `change` cycle.
- `cnt[k]` cannot overflow: it saturates by construction at STABLE_TICKS-1.
- STABLE_TICKS=1: commit on the first tick seen while mismatched.

## Timing
- Reset (async assert, while `rst_n`=0): `div_cnt`=0, `s1`=`s2`=0, `cnt`=0, `sw_db`=4'b0000, `rise`=`fall`=0, `change`=0, `any_on`=0, `tick`=0.
- Reset release is synchronous in effect: the first counting edge is the first `clk` rise with `rst_n`=1.
- Switches already on at reset release are treated as changes from 0 and debounced normally; no bypass.
- Latency, stable `sw` step to `sw_db` update, counted in `clk` edges after the edge that first samples the new value into `s1`: minimum 3+(STABLE_TICKS-1)(DIV+1), maximum 2+STABLE_TICKS(DIV+1). Defaults: 36..46.
- Reset asserted mid-debounce: all progress is lost and every output returns to its reset value immediately. No strobe is emitted on reset or on release.
- `div_cnt` free-runs; it is never restarted by switch activity.

## Test plan
- Reset values: hold `rst_n`=0 with `sw`=4'hF for 20 clk -> `sw_db`=0, `rise`/`fall`/`change`/`any_on`=0, `tick` never pulses.
- Clean step (DIV=3, STABLE_TICKS=2): `sw` 0->4'b0001 held -> `sw_db`=4'b0001 between edge 7 and 10 after the sampling edge. `rise`=4'b0001 and `change`=1 for exactly one cycle; `any_on`=1.
- Bounce rejection (DIV=3, STABLE_TICKS=2): toggle `sw[1]` every 3 clk for 40 clk, then hold 0 -> `sw_db[1]` stays 0, no `rise`/`fall` on bit 1, `change` never asserts.
- Independent and simultaneous: from `sw_db`=4'b0011, step `sw` to 4'b1100 at one edge -> a single cycle with `rise`=4'b1100, `fall`=4'b0011 and `change`=1; afterwards `sw_db`=4'b1100.
- Falling edge and any_on: from `sw_db`=4'b1000, step `sw` to 0 -> `fall`=4'b1000 for one cycle, then `sw_db`=0 and `any_on`=0 on the same cycle.
- Reset mid-debounce: with `cnt[2]`=1 of 2, pulse `rst_n` low for 1 clk, then hold `sw[2]`=1 -> full latency restarts from the release. No strobe is emitted during or after reset until the new commit.
